instr_cache_dm: RTL

- Direct-mapped, read-only instruction cache directly upstream of the core's fetch stage.
- Drives the core's instr_cache_instr_i and instr_cache_blocking_n_i.
- Serves hits combinationally in the same cycle. On a miss, fills a whole line from a burst memory port.
- Supports a single-cycle full invalidate (fence.i / flush).

---
 rtl/instr_cache_dm.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_cache_dm.sv
// Purpose : direct-mapped read-only instruction cache in front of the fetch stage;
//           hits are served combinationally, misses fill a whole line from a burst port.
// Latency : hit 0 cycles; miss-to-hit = 2 + grant wait + LINE_WORDS beat cycles.
// Backpressure: core is stalled via core_blocking_n_o=0; mem_req_o held until mem_gnt_i.
//
// Ports:
//   clk_i, rst_i (async active-low)
//   core_address_i[29:0] word address from fetch; core_instr_o[29:0] instruction bits [31:2]
//   core_blocking_n_o    1 = core_instr_o valid this cycle
//   flush_i              single-cycle invalidate of all lines
//   mem_req_o/mem_address_o/mem_gnt_i   line-fill request handshake
//   mem_rvalid_i/mem_rdata_i            in-order fill beats, word 0 first
module instr_cache_dm #(
  parameter int          LINE_WORDS = 4,
  parameter int          NUM_LINES  = 64,
  parameter logic [29:0] NOP_WORD   = 30'h4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] core_address_i,
  output logic [29:0] core_instr_o,
  output logic        core_blocking_n_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [29:0] mem_address_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = 30 - OFF - IDX;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_LINES-1:0] r_valid, w_valid_nxt;
  logic                 r_req, w_req_nxt;
  logic [29:0]          r_addr, w_addr_nxt;
  logic [OFF-1:0]       r_cnt, w_cnt_nxt;
  logic                 r_flushed, w_flushed_nxt;
  logic                 w_beat_we;
  logic                 w_tag_we;

  // Storage: only the valid vector is reset; data and tags are don't-care until valid.
  logic [29:0]     r_data [NUM_LINES*LINE_WORDS];
  logic [TAGW-1:0] r_tag  [NUM_LINES];

  // Lookup fields of the fetch address.
  logic [IDX-1:0]     w_index;
  logic [TAGW-1:0]    w_tag;
  logic [OFF+IDX-1:0] w_rd_ptr;
  logic [IDX-1:0]     w_miss_index;
  logic [TAGW-1:0]    w_miss_tag;
  logic [OFF+IDX-1:0] w_wr_ptr;
  logic               w_hit;
  logic               w_unused_rdata;

  assign w_index      = core_address_i[OFF+IDX-1:OFF];
  assign w_tag        = core_address_i[29:OFF+IDX];
  assign w_rd_ptr     = core_address_i[OFF+IDX-1:0];
  assign w_miss_index = r_addr[OFF+IDX-1:OFF];
  assign w_miss_tag   = r_addr[29:OFF+IDX];
  assign w_wr_ptr     = {w_miss_index, r_cnt};
  // The two low instruction bits are always 2'b11 for 32-bit encodings; not stored.
  assign w_unused_rdata = ^mem_rdata_i[1:0];

  // Lookups only count in IDLE so the core never sees a half-written line as a hit.
  assign w_hit = (r_state == S_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign core_blocking_n_o = w_hit;
  assign core_instr_o      = w_hit ? r_data[w_rd_ptr] : NOP_WORD;
  assign mem_req_o         = r_req;
  assign mem_address_o     = r_addr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_flushed <= w_flushed_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_beat_we) r_data[w_wr_ptr] <= mem_rdata_i[31:2];
    if (w_tag_we)  r_tag[w_miss_index] <= w_miss_tag;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_req_nxt     = r_req;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_flushed_nxt = r_flushed;
    w_beat_we     = 1'b0;
    w_tag_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_flushed_nxt = 1'b0;
        if (flush_i) begin
          w_valid_nxt = '0;
        end else if (!w_hit) begin
          w_addr_nxt  = {core_address_i[29:OFF], {OFF{1'b0}}};
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          w_valid_nxt   = '0;
          w_flushed_nxt = 1'b1;
        end
        // Beats seen here (including the grant cycle) belong to nothing we asked for.
        if (mem_gnt_i) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (flush_i) begin
          w_valid_nxt   = '0;
          w_flushed_nxt = 1'b1;
        end
        if (mem_rvalid_i) begin
          w_beat_we = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_BEAT) begin
            w_tag_we = 1'b1;
            // A flush anywhere in the fill (or on this very beat) leaves the line invalid.
            if (!(r_flushed || flush_i)) w_valid_nxt[w_miss_index] = 1'b1;
            w_flushed_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
